riscv_mc_controller: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core, the successor to the single-cycle CPU.

---
 rtl/riscv_mc_pkg.sv | 82 ++++++++
 rtl/riscv_mc_alu_dec.sv | 47 ++++
 rtl/riscv_mc_controller.sv | 218 +++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// ALU operations, immediate formats and datapath mux selects.
package riscv_mc_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_LUI,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLNK,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_alu_dec.sv
// ALU operation decoder: maps the FSM's ALU request plus funct fields to an
// ALUControl code and flags funct combinations that are not valid RV32I.
module riscv_mc_alu_dec
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  aluop_t     aluop,
    output logic [3:0] alu_control,
    output logic       illegal_f
);

    logic is_rtype;
    logic is_itype;
    logic [3:0] funct_ctl;

    always_comb begin
        is_rtype = (op == OP_RTYPE);
        is_itype = (op == OP_ITYPE);

        // funct7b5 is part of the immediate for most I-type ops; only SRAI uses it
        case (funct3)
            3'b000:  funct_ctl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_ctl = ALU_SLL;
            3'b010:  funct_ctl = ALU_SLT;
            3'b011:  funct_ctl = ALU_SLTU;
            3'b100:  funct_ctl = ALU_XOR;
            3'b101:  funct_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_ctl = ALU_OR;
            default: funct_ctl = ALU_AND;
        endcase

        illegal_f = 1'b0;
        if (is_rtype && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101))
            illegal_f = 1'b1;
        if (is_itype && funct7b5 && (funct3 == 3'b001))
            illegal_f = 1'b1;

        case (aluop)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences each instruction
// through a shared ALU and unified memory, with halt, illegal trap and bus watchdog.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter bit EN_HALT     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       LtU,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    aluop_t          aluop;
    logic [3:0]      alu_control;
    logic            illegal_f;
    logic            wd_expire;
    logic            branch_taken;
    logic            branch_bad;

    riscv_mc_alu_dec u_alu_dec (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .aluop       (aluop),
        .alu_control (alu_control),
        .illegal_f   (illegal_f)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = Lt;
            3'b101:  branch_taken = !Lt;
            3'b110:  branch_taken = LtU;
            3'b111:  branch_taken = !LtU;
            default: branch_taken = 1'b0;
        endcase
        branch_bad = (funct3 == 3'b010) || (funct3 == 3'b011);
        wd_expire  = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wd_q == WD_LAST);
    end

    // Next-state, watchdog and sticky-flag logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = illegal_f ? S_TRAP : S_EXECR;
                    OP_ITYPE:          state_d = illegal_f ? S_TRAP : S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    OP_SYSTEM:         state_d = EN_HALT ? S_HALT : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = branch_bad ? S_TRAP : S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRLNK;
            S_JALRLNK:  state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
        if (wd_expire)
            state_d = S_TRAP;

        wd_d = '0;
        if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && (state_d == state_q))
            wd_d = wd_q + 1'b1;

        illegal_d = illegal_q | ((state_d == S_TRAP) && (state_q != S_TRAP) && !wd_expire);
        bus_err_d = bus_err_q | wd_expire;
    end

    // Datapath controls decoded from the current state
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_SUB;
                PCWrite = branch_taken && !branch_bad;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_JALRLNK: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            default: ;
        endcase
    end

    assign ALUControl = alu_control;
    assign ImmSrc     = (state_q == S_IDLE) ? IMM_I : imm_src_of(op);
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: walks instruction classes, wait states,
// traps, halt, watchdog and asynchronous reset against hand-written control words.
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, Lt = 1'b0, LtU = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       halted, illegal, bus_err;

    int checks = 0;
    int failures = 0;

    // {req,we,AdrSrc,IRWrite,PCWrite,RegWrite,A[1:0],B[1:0],ResultSrc[1:0],ALUControl[3:0]}
    logic [15:0] ctl;
    logic [15:0] flags;
    assign ctl   = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
    assign flags = {13'd0, halted, illegal, bus_err};

    localparam logic [15:0] C_ZERO     = 16'h0000;
    localparam logic [15:0] C_FETCHW   = 16'h80A0;
    localparam logic [15:0] C_FETCHR   = 16'h98A0;
    localparam logic [15:0] C_DECODE   = 16'h0140;
    localparam logic [15:0] C_EXECR    = 16'h0200;
    localparam logic [15:0] C_EXECRSUB = 16'h0201;
    localparam logic [15:0] C_SRAI     = 16'h0249;
    localparam logic [15:0] C_ALUWB    = 16'h0400;
    localparam logic [15:0] C_MEMADR   = 16'h0240;
    localparam logic [15:0] C_MEMREAD  = 16'hA000;
    localparam logic [15:0] C_MEMWRITE = 16'hE000;
    localparam logic [15:0] C_MEMWB    = 16'h0410;
    localparam logic [15:0] C_BR_T     = 16'h0A01;
    localparam logic [15:0] C_BR_NT    = 16'h0201;
    localparam logic [15:0] C_JAL      = 16'h0980;
    localparam logic [15:0] C_JALR     = 16'h0A60;
    localparam logic [15:0] C_JALRLNK  = 16'h0180;

    riscv_mc_controller #(.MEM_TIMEOUT(8), .EN_HALT(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .Lt         (Lt),
        .LtU        (LtU),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic fetch_decode(input string tag);
        cyc(1'b1); check({tag, "_fetch"}, ctl, C_FETCHR);
        cyc(1'b1); check({tag, "_decode"}, ctl, C_DECODE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_ctl", ctl, C_ZERO);
        check("rst_flags", flags, 16'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset: everything low in IDLE
        repeat (2) @(negedge clk);
        #1;
        check("por_ctl", ctl, C_ZERO);
        check("por_flags", flags, 16'd0);
        check("por_imm", {13'd0, ImmSrc}, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // add x3,x1,x2 with zero-wait memory
        set_instr(7'b0110011, 3'b000, 1'b0);
        fetch_decode("add");
        cyc(1'b1); check("add_execr", ctl, C_EXECR);
        cyc(1'b1); check("add_aluwb", ctl, C_ALUWB);

        // lw: 3 wait cycles in FETCH, 2 in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0); check("lw_fetch_wait", ctl, C_FETCHW);
        end
        cyc(1'b1); check("lw_fetch", ctl, C_FETCHR);
        cyc(1'b0); check("lw_decode", ctl, C_DECODE);
        check("lw_imm", {13'd0, ImmSrc}, 16'd0);
        cyc(1'b0); check("lw_memadr", ctl, C_MEMADR);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0); check("lw_memread_wait", ctl, C_MEMREAD);
        end
        cyc(1'b1); check("lw_memread", ctl, C_MEMREAD);
        cyc(1'b0); check("lw_memwb", ctl, C_MEMWB);

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(1'b1); check("sw_fetch", ctl, C_FETCHR);
        cyc(1'b1); check("sw_decode", ctl, C_DECODE);
        check("sw_imm", {13'd0, ImmSrc}, 16'd1);
        cyc(1'b1); check("sw_memadr", ctl, C_MEMADR);
        cyc(1'b1); check("sw_memwrite", ctl, C_MEMWRITE);

        // beq taken / not taken, bltu taken, bge not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1;
        fetch_decode("beq1");
        check("beq_imm", {13'd0, ImmSrc}, 16'd2);
        cyc(1'b1); check("beq_taken", ctl, C_BR_T);
        Zero = 1'b0;
        fetch_decode("beq0");
        cyc(1'b1); check("beq_not_taken", ctl, C_BR_NT);
        set_instr(7'b1100011, 3'b110, 1'b0);
        LtU = 1'b1;
        fetch_decode("bltu");
        cyc(1'b1); check("bltu_taken", ctl, C_BR_T);
        set_instr(7'b1100011, 3'b101, 1'b0);
        Lt = 1'b1;
        LtU = 1'b0;
        fetch_decode("bge");
        cyc(1'b1); check("bge_not_taken", ctl, C_BR_NT);
        Lt = 1'b0;

        // sub and srai
        set_instr(7'b0110011, 3'b000, 1'b1);
        fetch_decode("sub");
        cyc(1'b1); check("sub_execr", ctl, C_EXECRSUB);
        cyc(1'b1); check("sub_aluwb", ctl, C_ALUWB);
        set_instr(7'b0010011, 3'b101, 1'b1);
        fetch_decode("srai");
        cyc(1'b1); check("srai_execi", ctl, C_SRAI);
        cyc(1'b1); check("srai_aluwb", ctl, C_ALUWB);

        // jal (4 cycles) and jalr (5 cycles)
        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_decode("jal");
        check("jal_imm", {13'd0, ImmSrc}, 16'd3);
        cyc(1'b1); check("jal_jal", ctl, C_JAL);
        cyc(1'b1); check("jal_aluwb", ctl, C_ALUWB);
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_decode("jalr");
        cyc(1'b1); check("jalr_jalr", ctl, C_JALR);
        cyc(1'b1); check("jalr_lnk", ctl, C_JALRLNK);
        cyc(1'b1); check("jalr_aluwb", ctl, C_ALUWB);

        // Watchdog: 8 unanswered FETCH cycles then bus_err trap
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0);
            check("wd_fetch_wait", ctl, C_FETCHW);
            check("wd_no_err", flags, 16'd0);
        end
        cyc(1'b0); check("wd_trap_ctl", ctl, C_ZERO);
        check("wd_bus_err", flags, 16'b001);
        cyc(1'b1); check("wd_trap_hold", ctl, C_ZERO);

        // Reset asserted mid-MEMWRITE drops the request immediately
        do_reset();
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_decode("rsw");
        cyc(1'b1); check("rsw_memadr", ctl, C_MEMADR);
        cyc(1'b0); check("rsw_memwrite", ctl, C_MEMWRITE);
        #2 reset = 1'b0;
        #1 check("rsw_async_drop", ctl, C_ZERO);
        check("rsw_flags", flags, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rsw_idle", ctl, C_ZERO);
        cyc(1'b0); check("rsw_refetch", ctl, C_FETCHW);

        // Illegal opcode: sticky for 100 cycles
        set_instr(7'b0000000, 3'b000, 1'b0);
        cyc(1'b1); check("ill_fetch", ctl, C_FETCHR);
        cyc(1'b1); check("ill_decode", ctl, C_DECODE);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1);
            check("ill_sticky", flags, 16'b010);
        end
        check("ill_ctl", ctl, C_ZERO);

        // ecall halts; no requests afterwards
        do_reset();
        set_instr(7'b1110011, 3'b000, 1'b0);
        fetch_decode("ecall");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            check("ecall_ctl", ctl, C_ZERO);
            check("ecall_halted", flags, 16'b100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
